gemm_result_collector: RTL and testbench

Consumer end of the GEMM MAC datapath. Accepts the stream of signed partial dot products produced by `mac_vector_adder_tree` instances and sums `cfg_chunks` consecutive partials into one output element, since one element spans K/N vector beats. Each element is scaled by an arithmetic right shift, saturated to `OUT_W`, and buffered in a small FIFO. The FIFO drains to the output writer over a valid/ready handshake.

---
 rtl/gemm_pkg.sv | 39 +++
 rtl/gemm_out_fifo.sv | 70 +++++++
 rtl/gemm_result_collector.sv | 151 +++++++++++++++
 tb/tb_gemm_result_collector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types, default widths and the saturation helper for the GEMM result collector.
package gemm_pkg;

  localparam int unsigned GEMM_ACC_W = 40;
  localparam int unsigned GEMM_OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } collector_state_t;

  typedef struct packed {
    logic [63:0] value;
    logic        clipped;
  } sat_res_t;

  // Clamp a signed 64-bit value to the signed range of out_w bits (out_w < 64).
  function automatic sat_res_t sat_trunc(input logic signed [63:0] v,
                                         input int unsigned out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_res_t           r;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (v > max_v) begin
      r.value   = max_v;
      r.clipped = 1'b1;
    end else if (v < min_v) begin
      r.value   = min_v;
      r.clipped = 1'b1;
    end else begin
      r.value   = v;
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/gemm_out_fifo.sv
// Small synchronous FIFO with registered storage, head output and full/empty flags.
module gemm_out_fifo #(
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [OUT_W-1:0] push_data,
  input  logic             pop,
  output logic [OUT_W-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !full_q;
  assign do_pop    = pop && !empty_q;
  assign head_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CntW'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
    end
  end

endmodule

// File: rtl/gemm_result_collector.sv
// Sums cfg_chunks partial dot products per element, scales, saturates and queues the results.
module gemm_result_collector
  import gemm_pkg::*;
#(
  parameter int unsigned IN_W       = 32,
  parameter int unsigned ACC_W      = GEMM_ACC_W,
  parameter int unsigned OUT_W      = GEMM_OUT_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       cfg_chunks,
  input  logic [15:0]      cfg_elems,
  input  logic [4:0]       cfg_shift,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  collector_state_t   state_q;
  collector_state_t   state_d;
  logic [7:0]         chunks_q;
  logic [15:0]        elems_q;
  logic [4:0]         shift_q;
  logic [7:0]         chunk_cnt_q;
  logic [15:0]        elem_cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic               sat_q;

  logic               start_ok;
  logic               accept;
  logic               last_chunk;
  logic               push;
  logic               last_elem;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  sat_res_t           res;
  logic [OUT_W-1:0]   push_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               unused_hi;

  assign start_ok   = (state_q == IDLE) && start;
  assign in_ready   = (state_q == ACCUM) && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign last_chunk = (chunk_cnt_q == chunks_q - 8'd1);
  assign push       = accept && last_chunk;
  assign last_elem  = (elem_cnt_q == elems_q - 16'd1);

  // Datapath: the first chunk of an element starts fresh, so chunks==1 needs no special case.
  always_comb begin
    in_ext    = ACC_W'(signed'(in_data));
    sum       = (chunk_cnt_q == 8'd0) ? in_ext : acc_q + in_ext;
    shifted   = sum >>> shift_q;
    res       = sat_trunc(64'(shifted), OUT_W);
    push_data = res.value[OUT_W-1:0];
  end

  assign unused_hi = ^res.value[63:OUT_W];

  // Job sequencing: start only from IDLE, leave ACCUM on the final element's last chunk.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (cfg_elems == 16'd0) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (push && last_elem) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done/busy are decoded from state so busy falls in the same cycle done pulses.
  always_comb begin
    done = (state_q == DRAIN) && fifo_empty;
    busy = (state_q == ACCUM) || ((state_q == DRAIN) && !fifo_empty);
    sat  = sat_q;
  end

  // State, latched configuration, counters, accumulator and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chunks_q    <= 8'd1;
      elems_q     <= '0;
      shift_q     <= '0;
      chunk_cnt_q <= '0;
      elem_cnt_q  <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        chunks_q    <= (cfg_chunks == 8'd0) ? 8'd1 : cfg_chunks;
        elems_q     <= cfg_elems;
        shift_q     <= cfg_shift;
        chunk_cnt_q <= '0;
        elem_cnt_q  <= '0;
        acc_q       <= '0;
        sat_q       <= 1'b0;
      end else if (accept) begin
        acc_q <= sum;
        if (last_chunk) begin
          chunk_cnt_q <= '0;
          elem_cnt_q  <= elem_cnt_q + 16'd1;
          if (res.clipped) begin
            sat_q <= 1'b1;
          end
        end else begin
          chunk_cnt_q <= chunk_cnt_q + 8'd1;
        end
      end
    end
  end

  gemm_out_fifo #(
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_gemm_result_collector.sv
// Directed self-checking bench for gemm_result_collector.
module tb_gemm_result_collector;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_chunks;
  logic [15:0] cfg_elems;
  logic [4:0]  cfg_shift;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        sat;

  int          checks;
  int          failures;
  int          done_cnt;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  gemm_result_collector #(
    .IN_W       (32),
    .ACC_W      (40),
    .OUT_W      (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_chunks (cfg_chunks),
    .cfg_elems  (cfg_elems),
    .cfg_shift  (cfg_shift),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .sat        (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record handshaken outputs and done pulses mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
    if (rst_n && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] ch, input logic [15:0] el, input logic [4:0] sh);
    @(posedge clk); #1;
    start = 1'b1; cfg_chunks = ch; cfg_elems = el; cfg_shift = sh;
    @(posedge clk); #1;
    start = 1'b0; cfg_chunks = 8'hAA; cfg_elems = 16'hBEEF; cfg_shift = 5'd7;
  endtask

  // Present one beat; returns 1ns after the edge that accepted it.
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n;
    n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s_out%0d", tag, i), got[i], exp_q[i]);
    end
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; cfg_chunks = '0; cfg_elems = '0; cfg_shift = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);
    rst_n = 1'b1;

    // Pass-through elements.
    do_start(8'd1, 16'd3, 5'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'd5); send(32'(-7)); send(32'd100);
    wait_done("t1_done", 50);
    exp_q = '{32'd5, 32'(-7), 32'd100};
    compare_outputs("t1");
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_sat", {31'd0, sat}, 32'd0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // Four-chunk accumulation with floor shift.
    got.delete(); done_cnt = 0;
    do_start(8'd4, 16'd2, 5'd1);
    send(32'd1); send(32'd2); send(32'd3);
    check("t2_no_early_valid", {31'd0, out_valid}, 32'd0);
    send(32'd4);
    check("t2_valid_e0", {31'd0, out_valid}, 32'd1);
    check("t2_data_e0", out_data, 32'd5);
    send(32'(-1)); send(32'(-1)); send(32'(-1));
    check("t2_no_valid_mid", {31'd0, out_valid}, 32'd0);
    send(32'(-2));
    check("t2_valid_e1", {31'd0, out_valid}, 32'd1);
    check("t2_data_e1", out_data, 32'(-3));
    wait_done("t2_done", 50);
    exp_q = '{32'd5, 32'(-3)};
    compare_outputs("t2");

    // Positive saturation.
    got.delete(); done_cnt = 0;
    do_start(8'd2, 16'd1, 5'd0);
    send(32'h7FFF_FFFF); send(32'h7FFF_FFFF);
    wait_done("t3_done", 50);
    exp_q = '{32'h7FFF_FFFF};
    compare_outputs("t3");
    check("t3_sat", {31'd0, sat}, 32'd1);

    // Backpressure: FIFO fills, then drains in order; start also clears sat.
    got.delete(); done_cnt = 0;
    out_ready = 1'b0;
    do_start(8'd1, 16'd6, 5'd0);
    check("t4_sat_cleared", {31'd0, sat}, 32'd0);
    send(32'd11); send(32'd12); send(32'd13); send(32'd14);
    in_valid = 1'b1; in_data = 32'd15;
    repeat (2) @(posedge clk);
    #1;
    check("t4_full_in_ready", {31'd0, in_ready}, 32'd0);
    check("t4_head", out_data, 32'd11);
    check("t4_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    check("t4_ready_during_pop", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("t4_ready_after_pop", {31'd0, in_ready}, 32'd1);
    send(32'd15); send(32'd16);
    wait_done("t4_done", 50);
    exp_q = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16};
    compare_outputs("t4");
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset mid-element, then a clean job.
    got.delete(); done_cnt = 0;
    do_start(8'd4, 16'd1, 5'd0);
    send(32'd100); send(32'd200);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_in_ready", {31'd0, in_ready}, 32'd0);
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_out_data", out_data, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_cnt), 32'd0);
    do_start(8'd2, 16'd1, 5'd0);
    send(32'd3); send(32'd4);
    wait_done("t5_done_after", 50);
    exp_q = '{32'd7};
    compare_outputs("t5");

    // chunks=0 acts as 1; a start mid-job is ignored.
    got.delete(); done_cnt = 0;
    do_start(8'd0, 16'd2, 5'd0);
    send(32'd9);
    do_start(8'd3, 16'd5, 5'd2);
    check("t6_busy", {31'd0, busy}, 32'd1);
    send(32'(-4));
    wait_done("t6_done", 50);
    exp_q = '{32'd9, 32'(-4)};
    compare_outputs("t6");
    check("t6_done_cnt", 32'(done_cnt), 32'd1);

    // Empty job.
    got.delete(); done_cnt = 0;
    do_start(8'd1, 16'd0, 5'd0);
    wait_done("t7_done", 2);
    check("t7_no_output", 32'(got.size()), 32'd0);
    check("t7_done_cnt", 32'(done_cnt), 32'd1);
    check("t7_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
